// File: rtl/acum_pkg.sv
// Shared types and constants for the result accumulator and its scaler.
// Contents: FSM state enum, accumulator/result widths, 32-bit saturation limits.
package acum_pkg;

  localparam int unsigned ACC_W   = 64;
  localparam int unsigned RES32_W = 32;

  // Signed 32-bit range expressed at accumulator width for direct compares
  localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -64'sh0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acum_state_t;

endpackage

// File: rtl/escalador_resultado.sv
// Combinational scaler: arithmetic right shift of a 64-bit sum down to 32 bits.
// Ports: value (64-bit signed sum), shift (0..31), scaled_c (32-bit result),
//        sat_c (saturation indicator, only when ACUM_SAT32_EN is defined).
// Macro ACUM_SAT32_EN: saturate to the signed 32-bit range instead of truncating.
module escalador_resultado
  import acum_pkg::*;
(
  input  logic [ACC_W-1:0]   value,
  input  logic [4:0]         shift,
  output logic [RES32_W-1:0] scaled_c
`ifdef ACUM_SAT32_EN
  ,
  output logic               sat_c
`endif
);

  logic signed [ACC_W-1:0] shifted;

  assign shifted = $signed(value) >>> shift;

`ifdef ACUM_SAT32_EN
  // Clamp to the signed 32-bit range, flagging any clamp
  always_comb begin
    sat_c    = 1'b0;
    scaled_c = shifted[RES32_W-1:0];
    if (shifted > SAT_MAX) begin
      scaled_c = 32'h7FFF_FFFF;
      sat_c    = 1'b1;
    end else if (shifted < SAT_MIN) begin
      scaled_c = 32'h8000_0000;
      sat_c    = 1'b1;
    end
  end
`else
  assign scaled_c = shifted[RES32_W-1:0];
`endif

endmodule

// File: rtl/acumulador_resultados.sv
// Block accumulator feeding the control/NIOS block: sums n_samples signed
// samples per block, emits a 64-bit sum and a shifted 32-bit result per block,
// and raises calculo_finalizado after n_results blocks (0 = free-running).
// Ports: clk, reset_n (sync, active low), enable (run/pause), reset_op (soft
//        clear), data_in/data_in_valid (sample stream), n_samples/n_results/
//        shift (run parameters, latched in IDLE), result_64/result_64_valid,
//        result_32/result_32_valid, calculo_finalizado, sat_flag (ACUM_SAT32_EN).
// Macro ACUM_SAT32_EN: saturating 32-bit result plus the sat_flag output.
module acumulador_resultados
  import acum_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                reset_op,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_in_valid,
  input  logic [31:0]         n_samples,
  input  logic [31:0]         n_results,
  input  logic [4:0]          shift,
  output logic [ACC_W-1:0]    result_64,
  output logic                result_64_valid,
  output logic [RES32_W-1:0]  result_32,
  output logic                result_32_valid,
  output logic                calculo_finalizado
`ifdef ACUM_SAT32_EN
  ,
  output logic                sat_flag
`endif
);

  acum_state_t        state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [31:0]        sample_cnt_q, sample_cnt_d;
  logic [31:0]        result_cnt_q, result_cnt_d;
  logic [31:0]        n_samples_q, n_samples_d;
  logic [31:0]        n_results_q, n_results_d;
  logic [4:0]         shift_q, shift_d;
  logic [ACC_W-1:0]   result_64_d;
  logic [RES32_W-1:0] result_32_d;
  logic               valid_d;
  logic               fin_d;

  logic signed [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0]        block_sum;
  logic [RES32_W-1:0]      scaled_c;
  logic [31:0]             result_cnt_inc;

  assign sample_ext     = ACC_W'(signed'(data_in));
  assign block_sum      = acc_q + sample_ext;
  assign result_cnt_inc = result_cnt_q + 32'd1;

`ifdef ACUM_SAT32_EN
  logic sat_c;
  logic sat_d;

  escalador_resultado u_escalador (
    .value    (block_sum),
    .shift    (shift_q),
    .scaled_c (scaled_c),
    .sat_c    (sat_c)
  );
`else
  escalador_resultado u_escalador (
    .value    (block_sum),
    .shift    (shift_q),
    .scaled_c (scaled_c)
  );
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    sample_cnt_d = sample_cnt_q;
    result_cnt_d = result_cnt_q;
    n_samples_d  = n_samples_q;
    n_results_d  = n_results_q;
    shift_d      = shift_q;
    result_64_d  = result_64;
    result_32_d  = result_32;
    valid_d      = 1'b0;
    fin_d        = calculo_finalizado;
`ifdef ACUM_SAT32_EN
    sat_d        = sat_flag;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          // A block length of 0 behaves as 1
          n_samples_d = (n_samples == 32'd0) ? 32'd1 : n_samples;
          n_results_d = n_results;
          shift_d     = shift;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (enable && data_in_valid) begin
          if (sample_cnt_q == n_samples_q - 32'd1) begin
            result_64_d  = block_sum;
            result_32_d  = scaled_c;
            valid_d      = 1'b1;
`ifdef ACUM_SAT32_EN
            sat_d        = sat_c;
`endif
            acc_d        = '0;
            sample_cnt_d = '0;
            result_cnt_d = result_cnt_inc;
            if ((n_results_q != 32'd0) && (result_cnt_inc == n_results_q)) begin
              state_d = DONE;
              fin_d   = 1'b1;
            end
          end else begin
            acc_d        = block_sum;
            sample_cnt_d = sample_cnt_q + 32'd1;
          end
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // Soft clear overrides everything above; IDLE keeps the datapath cleared
    if (reset_op || (state_q == IDLE)) begin
      acc_d        = '0;
      sample_cnt_d = '0;
      result_cnt_d = '0;
      result_64_d  = '0;
      result_32_d  = '0;
      valid_d      = 1'b0;
      fin_d        = 1'b0;
`ifdef ACUM_SAT32_EN
      sat_d        = 1'b0;
`endif
    end
    if (reset_op) begin
      state_d = IDLE;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      acc_q              <= '0;
      sample_cnt_q       <= '0;
      result_cnt_q       <= '0;
      n_samples_q        <= 32'd1;
      n_results_q        <= '0;
      shift_q            <= '0;
      result_64          <= '0;
      result_32          <= '0;
      result_64_valid    <= 1'b0;
      result_32_valid    <= 1'b0;
      calculo_finalizado <= 1'b0;
`ifdef ACUM_SAT32_EN
      sat_flag           <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      acc_q              <= acc_d;
      sample_cnt_q       <= sample_cnt_d;
      result_cnt_q       <= result_cnt_d;
      n_samples_q        <= n_samples_d;
      n_results_q        <= n_results_d;
      shift_q            <= shift_d;
      result_64          <= result_64_d;
      result_32          <= result_32_d;
      result_64_valid    <= valid_d;
      result_32_valid    <= valid_d;
      calculo_finalizado <= fin_d;
`ifdef ACUM_SAT32_EN
      sat_flag           <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_acumulador_resultados.sv
// Scoreboard bench for acumulador_resultados: directed scenarios plus
// randomized runs, checked against a block-list reference model.
module tb_acumulador_resultados;

  localparam int unsigned DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        reset_op;
  logic [DATA_W-1:0] data_in;
  logic        data_in_valid;
  logic [31:0] n_samples;
  logic [31:0] n_results;
  logic [4:0]  shift;
  logic [63:0] result_64;
  logic        result_64_valid;
  logic [31:0] result_32;
  logic        result_32_valid;
  logic        calculo_finalizado;
`ifdef ACUM_SAT32_EN
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  acumulador_resultados #(.DATA_W(DATA_W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .reset_op           (reset_op),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .n_samples          (n_samples),
    .n_results          (n_results),
    .shift              (shift),
    .result_64          (result_64),
    .result_64_valid    (result_64_valid),
    .result_32          (result_32),
    .result_32_valid    (result_32_valid),
    .calculo_finalizado (calculo_finalizado)
`ifdef ACUM_SAT32_EN
    ,
    .sat_flag           (sat_flag)
`endif
  );

  typedef struct {
    logic [63:0] r64;
    logic [31:0] r32;
    logic        sat;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  bit mon_on = 0;

  // Reference model: mode 0 idle, 1 running, 2 done
  int          m_mode = 0;
  longint      m_blk[$];
  int unsigned m_ns = 1, m_nr = 0, m_cnt = 0;
  int          m_sh = 0;
  logic [63:0] m_h64 = '0;
  logic [31:0] m_h32 = '0;
  bit          m_hsat = 0;
  bit          m_fin = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scale(input longint s, input int sh, output logic [31:0] r, output bit sat);
    longint v;
    v = s >>> sh;
    sat = 0;
    r = 32'(v);
`ifdef ACUM_SAT32_EN
    if (v > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF;
      sat = 1;
    end else if (v < -64'sh0000_0000_8000_0000) begin
      r = 32'h8000_0000;
      sat = 1;
    end
`endif
  endtask

  // Applies the behaviour of one clock edge given the inputs it sampled
  task automatic model_step();
    longint sum;
    exp_t e;
    if (!reset_n || reset_op) begin
      m_mode = 0;
      m_blk.delete();
      m_cnt = 0;
      m_h64 = '0;
      m_h32 = '0;
      m_hsat = 0;
      m_fin = 0;
    end else begin
      case (m_mode)
        0: if (enable) begin
          m_ns = (n_samples == 0) ? 1 : n_samples;
          m_nr = n_results;
          m_sh = int'(shift);
          m_mode = 1;
        end
        1: if (enable && data_in_valid) begin
          m_blk.push_back(longint'(signed'(data_in)));
          if (m_blk.size() == int'(m_ns)) begin
            sum = 0;
            foreach (m_blk[i]) sum += m_blk[i];
            e.r64 = sum;
            scale(sum, m_sh, e.r32, e.sat);
            q.push_back(e);
            m_h64 = e.r64;
            m_h32 = e.r32;
            m_hsat = e.sat;
            m_blk.delete();
            m_cnt++;
            if (m_nr != 0 && m_cnt == m_nr) begin
              m_mode = 2;
              m_fin = 1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    data_in = v;
    data_in_valid = 1'b1;
    cyc();
    data_in_valid = 1'b0;
  endtask

  task automatic soft_reset();
    reset_op = 1'b1;
    cyc();
    reset_op = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] ns, input logic [31:0] nr, input logic [4:0] sh);
    n_samples = ns;
    n_results = nr;
    shift = sh;
    enable = 1'b1;
    cyc();
  endtask

  // Monitor: pops the scoreboard on every result pulse, checks held state
  always @(negedge clk) begin
    if (mon_on) begin
      if (result_64_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(result_64_valid), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result_64", result_64, e.r64);
          chk("result_32", 64'(result_32), 64'(e.r32));
`ifdef ACUM_SAT32_EN
          chk("sat_flag", 64'(sat_flag), 64'(e.sat));
`endif
        end
      end else if (q.size() != 0) begin
        chk("missing_valid", 64'(result_64_valid), 64'd1);
        void'(q.pop_front());
      end
      chk("valid_coincident", 64'(result_32_valid), 64'(result_64_valid));
      chk("calculo_finalizado", 64'(calculo_finalizado), 64'(m_fin));
      chk("held_64", result_64, m_h64);
      chk("held_32", 64'(result_32), 64'(m_h32));
    end
  end

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    reset_op = 1'b0;
    data_in = '0;
    data_in_valid = 1'b0;
    n_samples = 32'd4;
    n_results = 32'd1;
    shift = 5'd0;
    cyc();
    mon_on = 1;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Basic block, single result, then samples after finish are ignored
    start_run(4, 1, 2);
    send(10); send(20); send(30); send(40);
    send(50); send(60);
    cyc();

    // Signed gapless blocks
    soft_reset();
    start_run(2, 3, 0);
    send(-5); send(-7); send(3); send(4); send(32767); send(1);
    send(9);
    cyc();

    // Pause with valid samples present and a parameter change during pause
    soft_reset();
    start_run(3, 1, 0);
    send(1);
    enable = 1'b0;
    data_in = 99;
    data_in_valid = 1'b1;
    n_samples = 1;
    repeat (5) cyc();
    enable = 1'b1;
    data_in_valid = 1'b0;
    send(2); send(3);
    cyc();

    // Soft reset mid-block together with a valid sample, then fresh run
    soft_reset();
    start_run(4, 1, 0);
    send(5); send(6);
    data_in = 7;
    data_in_valid = 1'b1;
    reset_op = 1'b1;
    cyc();
    reset_op = 1'b0;
    data_in_valid = 1'b0;
    enable = 1'b0;
    cyc();
    start_run(4, 1, 1);
    send(100); send(-3); send(8); send(1);
    cyc();

    // Free-running with n_samples = 0
    soft_reset();
    start_run(0, 0, 0);
    for (int i = 0; i < 10; i++) send(32'($urandom_range(0, 2000)) - 32'd1000);
    cyc();

    // Large samples: saturation or truncation of the 32-bit result
    soft_reset();
    start_run(2, 1, 0);
    send(32'h7FFF_FFFF); send(32'h7FFF_FFFF);
    cyc();
    soft_reset();
    start_run(2, 1, 0);
    send(32'h8000_0000); send(32'h8000_0000);
    cyc();

    // Randomized runs
    for (int run = 0; run < 25; run++) begin
      soft_reset();
      enable = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        data_in = $urandom;
        data_in_valid = 1'($urandom_range(0, 1));
        cyc();
      end
      data_in_valid = 1'b0;
      start_run($urandom_range(0, 5), $urandom_range(0, 4), 5'($urandom_range(0, 31)));
      for (int c = 0; c < 40; c++) begin
        enable = ($urandom_range(0, 3) != 0);
        data_in_valid = ($urandom_range(0, 3) != 0);
        data_in = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
        if ($urandom_range(0, 9) == 0) n_samples = $urandom_range(0, 5);
        if ($urandom_range(0, 9) == 0) shift = 5'($urandom_range(0, 31));
        reset_op = ($urandom_range(0, 59) == 0);
        reset_n = ($urandom_range(0, 99) != 0);
        cyc();
        reset_op = 1'b0;
        reset_n = 1'b1;
      end
      data_in_valid = 1'b0;
    end

    enable = 1'b0;
    repeat (3) cyc();
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acumulador_resultados.md
# acumulador_resultados

- Sits directly upstream of the control/NIOS block and produces its `result_0_64_bit` / `result_0_32_bit` streams and its `calculo_finalizado` flag.
- Accumulates signed samples in blocks of `n_samples` into a 64-bit sum and emits one 64-bit result plus one scaled 32-bit result per block.
- After `n_results` blocks it raises `calculo_finalizado` and stops.
- Run parameters arrive from the control block's parameter outputs; `enable` and `reset_op` come from its enable and reset outputs.

## Interface

**Parameters**

- `DATA_W`, default 16: width of the signed input sample (2..32).

**Ports**

- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: run enable from the control block. While low, the block holds its state.
- `reset_op` in 1: synchronous, active-high soft clear (driven from `reset_from_control`).
- `data_in` in DATA_W: signed input sample.
- `data_in_valid` in 1: sample strobe.
- `n_samples` in 32: samples per result, unsigned. A value of 0 is treated as 1.
- `n_results` in 32: results per run, unsigned. A value of 0 means free-running (never finishes).
- `shift` in 5: arithmetic right shift applied to produce the 32-bit result.
- `result_64` out 64: signed block sum.
- `result_64_valid` out 1: one-cycle pulse qualifying `result_64`.
- `result_32` out 32: scaled result.
- `result_32_valid` out 1: one-cycle pulse, always coincident with `result_64_valid`.
- `calculo_finalizado` out 1: run complete, level.

## Operation

- **States:** IDLE, ACCUM, DONE.
- **IDLE:**
  - Accumulator, counters and outputs are cleared.
  - When `enable`=1, latch `n_samples`, `n_results` and `shift`, then go to ACCUM on the next cycle.
  - Samples presented while in IDLE are dropped.
- **ACCUM:**
  - On each cycle with `enable`=1 and `data_in_valid`=1, add the sign-extended `data_in` to the 64-bit accumulator and increment `sample_cnt`.
  - While `enable`=0: samples are ignored and all counters and the accumulator hold (pause).
- **Block end:** a valid sample arriving while `sample_cnt` = N−1 ends the block.
  - `result_64` <= acc + sample.
  - Both valid strobes pulse.
  - acc <= 0 and `sample_cnt` <= 0.
  - `result_cnt` increments.
  - The next sample may arrive in the following cycle with no gap and no sample loss.
- **Finish:** if `n_results`≠0 and the emitted result is number `n_results`, go to DONE.
- **DONE:**
  - `calculo_finalizado`=1, held.
  - Samples are ignored.
  - Leave DONE only via `reset_op` or `reset_n`, both of which return to IDLE.
- **Arithmetic:**
  - The sum wraps modulo 2^64; no overflow detection.
  - `result_32` = low 32 bits of (`result_64` >>> `shift`), arithmetic shift.
- **Latched parameters:** changes to `n_samples`, `n_results` or `shift` during ACCUM or DONE have no effect until the next pass through IDLE.
- **Simultaneous events:**
  - `reset_op` beats `data_in_valid`; that sample is dropped.
  - `reset_op` beats a block end; no valid pulse is produced.
  - `reset_n` beats everything.
- **Free-running mode:** `result_cnt` wraps at 2^32 with no effect on operation.

## Timing

- **Reset values** (after `reset_n`=0 or `reset_op`=1):
  - State = IDLE.
  - `result_64`=0, `result_32`=0.
  - Both valids=0.
  - `calculo_finalizado`=0.
  - All counters and the accumulator = 0.
- **Start latency:** `enable` sampled high in IDLE leads to ACCUM one cycle later. The first sample accepted is in the cycle after entry.
- **Result latency:** results and valids are registered. They pulse exactly 1 cycle after the clock edge that accepts the last sample of a block.
- **Held outputs:** `result_64` and `result_32` hold their value until the next block end.
- **Finish flag:** `calculo_finalizado` rises in the same cycle as the final result's valid pulse.
- **Throughput:** one sample per cycle sustained. With `n_samples`=1, one result per accepted sample.

## Configuration

- **Macro:** `ACUM_SAT32_EN`.
- **Defined:**
  - `result_32` saturates: (`result_64` >>> `shift`) > 2^31−1 gives 32'h7FFFFFFF; values < −2^31 give 32'h80000000.
  - Extra output port `sat_flag` (out, 1 bit) is registered with the result. It is high for the result that saturated and cleared on reset.
- **Undefined:** truncation to the low 32 bits as above, and no `sat_flag` port.

## Structure

- **Shared package `acum_pkg`:**
  - State enum `acum_state_t` (IDLE, ACCUM, DONE).
  - Constants `ACC_W=64` and `RES32_W=32`.
  - Saturation limits `SAT_MAX` / `SAT_MIN`.
- **Sub-module `escalador_resultado`:** combinational shift-and-scale from 64 bits to 32 bits. It contains the `ACUM_SAT32_EN` logic and is instantiated once. Output registers stay in the parent block.

## Test plan

- **Basic block, single result:** DATA_W=16, `n_samples`=4, `n_results`=1, `shift`=2, samples 10, 20, 30, 40 back-to-back.
  - `result_64`=100 and `result_32`=25, both valids pulsing one cycle after the 4th sample.
  - `calculo_finalizado`=1 in the same cycle, then further samples ignored.
- **Signed, gapless blocks:** `n_samples`=2, `n_results`=3, samples −5, −7, 3, 4, 32767, 1 continuous.
  - Results −12, 7, 32768 on consecutive blocks with no dropped sample.
  - Finish on the third result.
- **Pause and parameter latching:** in ACCUM with `n_samples`=3, send 1, then drop `enable` for 5 cycles with `data_in_valid`=1 and value 99, then restore `enable` and send 2, 3.
  - Result = 6.
  - A change of `n_samples` to 1 during the pause has no effect.
- **Soft reset mid-block:** after 2 of 4 samples, assert `reset_op` for one cycle together with a valid sample.
  - State=IDLE, all outputs 0, no valid pulse.
  - A new run after `enable` produces a correct fresh sum.
- **Free-running and n_samples=0:** `n_results`=0, `n_samples`=0, 10 samples.
  - 10 results, each equal to its own sample.
  - `calculo_finalizado` stays 0.
- **`ACUM_SAT32_EN` build:** `n_samples`=2, `shift`=0, DATA_W=32, samples 0x7FFFFFFF, 0x7FFFFFFF.
  - `result_64`=0xFFFFFFFE, `result_32`=0x7FFFFFFF, `sat_flag`=1.
  - Without the macro: `result_32`=0xFFFFFFFE.
